// File: rtl/bus_width_pkg.sv
// Shared definitions for the width-adapter family: MODE encodings and a
// small decode helper used by every block that accepts a MODE input.
package bus_width_pkg;

  typedef enum logic [1:0] {
    MODE_PACK = 2'b00,
    MODE_ZEXT = 2'b01,
    MODE_SEXT = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // The reserved code falls back to packing, so only two codes select a single-beat extend.
  function automatic logic is_extend_mode(input logic [1:0] mode);
    return (mode == MODE_ZEXT) || (mode == MODE_SEXT);
  endfunction

endpackage

// File: rtl/bus_extend.sv
// Combinational zero/sign extension of one IN_W beat to OUT_W bits.
// Also usable on its own in place of the old fixed 8-to-26 splitter.
module bus_extend #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_sign,
  output logic [OUT_W-1:0] o_data
);

  logic w_fill;

  assign w_fill = i_sign & i_data[IN_W-1];

  for (genvar g = 0; g < OUT_W; g++) begin : g_bit
    if (g < IN_W) begin : g_in
      assign o_data[g] = i_data[g];
    end else begin : g_ext
      assign o_data[g] = w_fill;
    end
  end

endmodule

// File: rtl/bus_width_packer.sv
// Widens a narrow valid/ready beat stream to an IN_W*RATIO word bus by packing
// RATIO beats little-endian, or by zero/sign-extending single beats; FLUSH emits a partial word.
module bus_width_packer
  import bus_width_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int BW    = $clog2(RATIO + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            MODE,
  input  logic [IN_W-1:0]       IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  FLUSH,
  output logic [IN_W*RATIO-1:0] OUT_DATA,
  output logic [BW-1:0]         OUT_BEATS,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY
);

  localparam int              OUT_W      = IN_W * RATIO;
  localparam logic [BW-1:0]   LAST_CNT   = BW'(RATIO - 1);
  localparam logic [BW-1:0]   FULL_BEATS = BW'(RATIO);

  logic [OUT_W-1:0] r_acc;
  logic [BW-1:0]    r_cnt;
  logic             r_fp;
  logic [OUT_W-1:0] r_out_data;
  logic [BW-1:0]    r_out_beats;
  logic             r_out_valid;

  logic             w_out_free;
  logic             w_accept;
  logic             w_cnt_zero;
  logic             w_is_ext;
  logic             w_sign;
  logic             w_fp_eff;
  logic             w_flush_emit;
  logic [OUT_W-1:0] w_beat_wide;
  logic [OUT_W-1:0] w_beat_shifted;
  logic [OUT_W-1:0] w_acc_merged;
  logic [OUT_W-1:0] w_ext_data;
  logic [OUT_W-1:0] w_acc_nxt;
  logic [BW-1:0]    w_cnt_nxt;
  logic             w_load;
  logic [OUT_W-1:0] w_load_data;
  logic [BW-1:0]    w_load_beats;
  logic             w_fp_nxt;

  // Handshake: a transfer happens on a rising edge where valid && ready; a producer
  // holds data stable while valid && !ready, and ready never waits on valid.
  assign w_out_free = !r_out_valid || OUT_READY;
  assign IN_READY   = w_out_free;
  assign w_accept   = IN_VALID && w_out_free;

  // MODE only matters at a word boundary; mid-word beats always pack.
  assign w_cnt_zero = (r_cnt == '0);
  assign w_is_ext   = w_cnt_zero && is_extend_mode(MODE);
  assign w_sign     = (MODE == MODE_SEXT);

  assign w_beat_wide    = {{(OUT_W - IN_W){1'b0}}, IN_DATA};
  assign w_beat_shifted = w_beat_wide << (int'(r_cnt) * IN_W);
  assign w_acc_merged   = r_acc | w_beat_shifted;

  // A FLUSH arriving this cycle acts immediately when nothing else claims the output.
  assign w_fp_eff     = r_fp || FLUSH;
  assign w_flush_emit = w_fp_eff && !w_cnt_zero && w_out_free && !w_accept;

  bus_extend #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_extend (
    .i_data (IN_DATA),
    .i_sign (w_sign),
    .o_data (w_ext_data)
  );

  always_comb begin
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_load       = 1'b0;
    w_load_data  = r_out_data;
    w_load_beats = r_out_beats;
    if (w_accept && w_is_ext) begin
      w_load       = 1'b1;
      w_load_data  = w_ext_data;
      w_load_beats = BW'(1);
    end else if (w_accept) begin
      if (r_cnt == LAST_CNT) begin
        w_load       = 1'b1;
        w_load_data  = w_acc_merged;
        w_load_beats = FULL_BEATS;
        w_acc_nxt    = '0;
        w_cnt_nxt    = '0;
      end else begin
        w_acc_nxt = w_acc_merged;
        w_cnt_nxt = r_cnt + BW'(1);
      end
    end else if (w_flush_emit) begin
      // Upper beats of r_acc are already zero because the accumulator clears per word.
      w_load       = 1'b1;
      w_load_data  = r_acc;
      w_load_beats = r_cnt;
      w_acc_nxt    = '0;
      w_cnt_nxt    = '0;
    end
    w_fp_nxt = w_fp_eff && (w_cnt_nxt != '0) && !w_flush_emit;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_fp        <= 1'b0;
      r_out_data  <= '0;
      r_out_beats <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_fp  <= w_fp_nxt;
      if (w_load) begin
        r_out_data  <= w_load_data;
        r_out_beats <= w_load_beats;
        r_out_valid <= 1'b1;
      end else if (OUT_READY) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign OUT_DATA  = r_out_data;
  assign OUT_BEATS = r_out_beats;
  assign OUT_VALID = r_out_valid;

endmodule

// File: doc/bus_width_packer.md
# bus_width_packer

Parametrised successor to the fixed 8-to-26 bus splitter. It widens a narrow input stream to a wide output bus and has three modes:
- packing RATIO consecutive input beats into one word;
- zero-extending single beats;
- sign-extending single beats.

It sits between narrow producers (byte-serial peripherals, UART/SPI deserialisers) and the wide internal datapath. Both sides use valid/ready handshakes, and a flush emits partially filled words.

## Interface
Parameters:
- IN_W, 8, input beat width in bits (≥1).
- RATIO, 4, input beats per packed word (≥2). OUT_W = IN_W*RATIO is derived, not a parameter.
- BW, $clog2(RATIO+1), width of the OUT_BEATS field (derived).

Ports:
- CLK, input, 1, clock. One clock; all logic rises on it.
- RST, input, 1, reset. Synchronous, active-high.
- MODE, input, 2, mode select. 00 pack, 01 zero-extend, 10 sign-extend, 11 reserved (treated as 00).
- IN_DATA, input, IN_W, input beat.
- IN_VALID, input, 1, input beat present.
- IN_READY, output, 1, block accepts a beat this cycle.
- FLUSH, input, 1, single-cycle request to emit the partial word.
- OUT_DATA, output, OUT_W, output word.
- OUT_BEATS, output, BW, number of valid input beats in OUT_DATA (1..RATIO).
- OUT_VALID, output, 1, output word present.
- OUT_READY, input, 1, consumer accepts the word.

## Operation
- State:
  - accumulator ACC, OUT_W bits;
  - beat counter CNT, 0..RATIO-1;
  - flush-pending flag FP;
  - output register (OUT_DATA, OUT_BEATS, OUT_VALID).
- IN_READY = !OUT_VALID || OUT_READY. This is combinational, and any accepted beat may need the output register.
- A beat is accepted when IN_VALID && IN_READY.
- Packing order is little-endian: beat k of a word lands in bits [k*IN_W +: IN_W].
- MODE is sampled only on an accepted beat with CNT==0. While CNT>0, the block stays in pack mode until the word completes or is flushed.
- Pack, non-final beat: write it into ACC and increment CNT.
- Pack, final beat (CNT==RATIO-1):
  - OUT_DATA gets ACC merged with the beat;
  - OUT_BEATS = RATIO, OUT_VALID = 1;
  - CNT and ACC clear to 0.
- Extend modes: OUT_DATA gets IN_DATA zero- or sign-extended to OUT_W, OUT_BEATS = 1, OUT_VALID = 1. CNT is unchanged (it is 0).
- FLUSH sets FP. FP is ignored and cleared if CNT==0 after any same-cycle beat has been accepted.
- While FP && CNT>0 and the output register is free (!OUT_VALID || OUT_READY) and no beat is accepted that cycle:
  - emit ACC with the unfilled upper beats zero;
  - OUT_BEATS = CNT;
  - clear CNT, ACC and FP.
- FLUSH in the same cycle as an accepted beat: the beat is included first. If that beat completes the word, FP is cleared with no extra output. Otherwise the partial word is emitted on the next cycle in which the output register is free.
- Output register: OUT_VALID clears on OUT_READY unless it is reloaded in the same cycle. OUT_DATA and OUT_BEATS are held stable while OUT_VALID && !OUT_READY.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_BEATS=0, CNT=0, ACC=0, FP=0.
  - IN_READY is 1 out of reset, since it is combinational from OUT_VALID.
- RST mid-word discards ACC and any pending output. The next accepted beat is beat 0 of a new word.
- Latency: the cycle after the final beat (pack) or the single beat (extend) is accepted, OUT_VALID=1.
- Flush latency: one cycle after FLUSH if the output register is free, else one cycle after it frees.
- Throughput: with OUT_READY tied high, one beat per cycle is sustained in all modes, with no bubbles between words.

## Structure
- Shared package bus_width_pkg holds the MODE encodings (MODE_PACK, MODE_ZEXT, MODE_SEXT) for reuse by other width-adapter blocks.
- One sub-module, bus_extend: combinational zero/sign extension, parametrised IN_W and OUT_W. It also serves as a drop-in replacement for the old fixed splitter.
- Counter, accumulator, flush logic and output register live in the top.

## Test plan
All scenarios use IN_W=8, RATIO=4.
1. Pack, OUT_READY=1: beats 0x11,0x22,0x33,0x44 back-to-back → OUT_DATA=0x44332211, OUT_BEATS=4, OUT_VALID the cycle after 0x44 is accepted.
2. Extend modes:
   - MODE=01, beat 0x80 → OUT_DATA=0x00000080, OUT_BEATS=1.
   - MODE=10, beat 0x80 → OUT_DATA=0xFFFFFF80.
   - MODE changed to 01 after 2 packed beats → ignored until the word completes.
3. Flush: beats 0xAA,0xBB then FLUSH → OUT_DATA=0x0000BBAA, OUT_BEATS=2. FLUSH together with the 3rd beat 0xCC → 0x00CCBBAA, OUT_BEATS=3.
4. Backpressure: OUT_READY=0 after word 0x44332211 → IN_READY=0, data held stable for 5 cycles. Next beats accepted only after OUT_READY=1, with no loss or duplication.
5. Reset: 2 beats, RST for one cycle, then 0x01..0x04 → single word 0x04030201 and no output of the discarded beats.
6. Idle FLUSH with CNT=0 → no OUT_VALID; FP clear the following cycle.
